sys_arr_drain: RTL and testbench
================================

SYS_ARR_DRAIN -- requirements
Module: sys_arr_drain

Interface
REQ-001 SHALL have parameter SYS_ARR_SIZE, default 8: array columns, and rows per drain.
REQ-002 SHALL have parameter PE_OUT_WIDTH, default 32: width of one result element.
REQ-003 SHALL have parameter START_LAT, default 2, legal range 1..15: cycles from the accepted start to column 0 row 0 on result_in.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: request to drain one SYS_ARR_SIZE-row result tile.
REQ-007 SHALL have port start_ready, output, 1 bit: start is accepted when start and start_ready are both high.
REQ-008 SHALL have port result_in, input, PE_OUT_WIDTH*SYS_ARR_SIZE bits: skewed array output; column j occupies bits [(j+1)*PE_OUT_WIDTH-1 : j*PE_OUT_WIDTH].
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a deskewed row.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the row.
REQ-011 SHALL have port out_data, output, PE_OUT_WIDTH*SYS_ARR_SIZE bits: deskewed row, same column packing as result_in.
REQ-012 SHALL have port out_row, output, $clog2(SYS_ARR_SIZE) bits: row index of out_data.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the last row of a tile is written to the FIFO.

Function
REQ-014 Start SHALL be accepted at cycle T only when the FSM is IDLE and the FIFO has SYS_ARR_SIZE free entries; start_ready SHALL be high exactly then.
REQ-015 The FSM SHALL have 3 states: IDLE, WAIT, CAPTURE. Transitions: IDLE->WAIT on accepted start; WAIT->CAPTURE after START_LAT-1 cycles in WAIT; CAPTURE->IDLE after 2*SYS_ARR_SIZE-1 cycles in CAPTURE.
REQ-016 Column j row r SHALL be sampled from result_in in cycle T+START_LAT+r+j.
REQ-017 Column j SHALL be delayed by SYS_ARR_SIZE-1-j register stages, so all columns of row r align in cycle T+START_LAT+r+SYS_ARR_SIZE-1.
REQ-018 The aligned row r SHALL be written to the FIFO at the end of that cycle; rows SHALL be written in order 0..SYS_ARR_SIZE-1, one per cycle, with no gaps.
REQ-019 done SHALL pulse in the cycle that row SYS_ARR_SIZE-1 is written.
REQ-020 The FIFO SHALL hold 2*SYS_ARR_SIZE rows with their row indices and use first-word-fall-through: out_valid SHALL rise the cycle after the first write.
REQ-021 A row SHALL be popped when out_valid and out_ready are both high; a push and a pop in the same cycle SHALL both take effect and leave the occupancy unchanged.
REQ-022 out_data and out_row SHALL stay stable while out_valid is high and out_ready is low.
REQ-023 result_in SHALL be ignored in IDLE and by the delay lines outside the capture window; data values SHALL pass through unmodified except as set by REQ-028.
REQ-024 A new start SHALL be acceptable in the cycle after CAPTURE->IDLE if FIFO space allows; back-to-back tiles SHALL NOT corrupt rows still in the FIFO.

Reset
REQ-025 While reset is low at a rising edge: FSM->IDLE, counters->0, FIFO emptied, delay lines->0.
REQ-026 Reset values: out_valid=0, out_data=0, out_row=0, done=0; start_ready=1 from the first cycle after reset is released.
REQ-027 Reset mid-drain SHALL abandon the tile; no partial row SHALL appear after reset is released.

Configuration
REQ-028 With SYS_ARR_DRAIN_RELU_EN defined, each element of out_data, read as signed, SHALL be replaced by 0 when negative. Without the macro, out_data SHALL equal the stored data bit-exactly.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the derived constants ROW_IDX_W=$clog2(SYS_ARR_SIZE) and FIFO_DEPTH=2*SYS_ARR_SIZE.
REQ-030 The FIFO SHALL be one sub-module, sync_fifo, parameterised by width and depth; the per-column delay lines SHALL be built with generate loops.

Verification
REQ-031 Scenario: N=8, START_LAT=2, start at T=10, column j row r drives value 100*r+j in cycle 12+r+j, out_ready=1 -> row r written in cycle 19+r, out_valid first high in cycle 20, out_data row 0 = {7,6,...,0}, rows 0..7 in order, done pulse in cycle 26.
REQ-032 Scenario: same stimulus, out_ready=0 for 20 cycles -> FIFO holds 8 rows, start_ready=1 after the drain (8 entries free), a second start is accepted; 16 entries occupied, then start_ready=0.
REQ-033 Scenario: out_ready toggling 1/0 each cycle -> every row is delivered exactly once, and out_data is stable on stall cycles.
REQ-034 Scenario: reset asserted low in cycle 22 of REQ-031 -> out_valid=0 next cycle, no rows afterwards, start_ready=1 after reset is released.
REQ-035 Scenario: with SYS_ARR_DRAIN_RELU_EN, column 3 row 0 = 32'hFFFF_FFF6 (-10) -> out element 0; without the macro -> 32'hFFFF_FFF6.

Source files
------------

// File: rtl/sys_arr_drain_pkg.sv
// sys_arr_drain_pkg: drain FSM state type and sizing constants shared by the drain block.
package sys_arr_drain_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPTURE} state_t;

    localparam int DEF_SYS_ARR_SIZE = 8;
    localparam int ROW_IDX_W        = $clog2(DEF_SYS_ARR_SIZE);
    localparam int FIFO_DEPTH       = 2 * DEF_SYS_ARR_SIZE;

    // Same derivations as above, for instances that override the array size.
    function automatic int row_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int fifo_depth(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/sys_arr_drain_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous active-low reset.
// o_data reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_cnt != '0);
    assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
            if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    assign o_valid = (r_cnt != '0);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

endmodule

// File: rtl/sys_arr_drain.sv
// sys_arr_drain: deskews a systolic array's skewed result rows into a FWFT row FIFO.
// Define SYS_ARR_DRAIN_RELU_EN to clamp negative output elements to zero.
module sys_arr_drain
    import sys_arr_drain_pkg::*;
#(
    parameter int SYS_ARR_SIZE = 8,
    parameter int PE_OUT_WIDTH = 32,
    parameter int START_LAT    = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 start_ready,
    input  logic [PE_OUT_WIDTH*SYS_ARR_SIZE-1:0] result_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PE_OUT_WIDTH*SYS_ARR_SIZE-1:0] out_data,
    output logic [$clog2(SYS_ARR_SIZE)-1:0]      out_row,
    output logic                                 done
);

    localparam int W     = PE_OUT_WIDTH;
    localparam int ROW_W = row_idx_w(SYS_ARR_SIZE);
    localparam int DEPTH = fifo_depth(SYS_ARR_SIZE);
    localparam int CNT_W = $clog2(2 * SYS_ARR_SIZE + START_LAT);
    localparam int FW    = W * SYS_ARR_SIZE + ROW_W;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic                        w_wait_end;
    logic                        w_cap_end;
    logic                        w_push;
    logic [ROW_W-1:0]            w_row_idx;
    logic [W*SYS_ARR_SIZE-1:0]   w_row;
    logic [FW-1:0]               w_fifo_out;
    logic [$clog2(DEPTH+1)-1:0]  w_count;

    assign start_ready = (r_state == ST_IDLE) && (int'(w_count) <= DEPTH - SYS_ARR_SIZE);
    assign w_wait_end  = (r_cnt == CNT_W'(START_LAT - 2));
    assign w_cap_end   = (r_cnt == CNT_W'(2 * SYS_ARR_SIZE - 2));
    assign w_push      = (r_state == ST_CAPTURE) && (r_cnt >= CNT_W'(SYS_ARR_SIZE - 1));
    assign w_row_idx   = ROW_W'(r_cnt - CNT_W'(SYS_ARR_SIZE - 1));
    assign done        = w_push && w_cap_end;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (start && start_ready) w_state_nxt = (START_LAT == 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                w_cnt_nxt   = w_wait_end ? '0 : r_cnt + CNT_W'(1);
                w_state_nxt = w_wait_end ? ST_CAPTURE : ST_WAIT;
            end
            ST_CAPTURE: begin
                w_cnt_nxt   = w_cap_end ? '0 : r_cnt + CNT_W'(1);
                w_state_nxt = w_cap_end ? ST_IDLE : ST_CAPTURE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Column j waits SYS_ARR_SIZE-1-j stages; only capture-window samples enter.
    for (genvar j = 0; j < SYS_ARR_SIZE; j++) begin : g_col
        localparam int D = SYS_ARR_SIZE - 1 - j;
        logic [W-1:0] w_in;
        assign w_in = (r_state == ST_CAPTURE) ? result_in[j*W +: W] : '0;
        if (D == 0) begin : g_pass
            assign w_row[j*W +: W] = w_in;
        end else begin : g_dly
            logic [W-1:0] r_dly [D];
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int k = 0; k < D; k++) r_dly[k] <= '0;
                end else begin
                    r_dly[0] <= w_in;
                    for (int k = 1; k < D; k++) r_dly[k] <= r_dly[k-1];
                end
            end
            assign w_row[j*W +: W] = r_dly[D-1];
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({w_row_idx, w_row}),
        .i_pop   (out_ready),
        .o_data  (w_fifo_out),
        .o_valid (out_valid),
        .o_count (w_count)
    );

    assign out_row = w_fifo_out[FW-1 -: ROW_W];

`ifdef SYS_ARR_DRAIN_RELU_EN
    for (genvar j = 0; j < SYS_ARR_SIZE; j++) begin : g_relu
        assign out_data[j*W +: W] = w_fifo_out[j*W + W - 1] ? '0 : w_fifo_out[j*W +: W];
    end
`else
    assign out_data = w_fifo_out[W*SYS_ARR_SIZE-1:0];
`endif

endmodule

// File: tb/tb_sys_arr_drain.sv
// tb_sys_arr_drain: randomized scoreboard bench; expected rows are queued when a start is
// accepted and a negedge monitor compares every delivered row, done pulse and stall.
module tb_sys_arr_drain;

    localparam int N = 8;
    localparam int W = 32;
    localparam int L = 2;

    typedef struct {
        logic [W*N-1:0] d;
        int             r;
    } row_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           start_ready;
    logic [W*N-1:0] result_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W*N-1:0] out_data;
    logic [2:0]     out_row;
    logic           done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   rdy_mode = 0;
    int   tile_mode = 0;
    int   cur_t = 0;
    bit   cur_valid = 0;
    int   exp_done = -1;
    logic [W-1:0] cur_data [N][N];
    row_t exp_q[$];
    bit   stall = 0;
    logic [W*N-1:0] st_data;
    logic [2:0]     st_row;

    sys_arr_drain #(
        .SYS_ARR_SIZE (N),
        .PE_OUT_WIDTH (W),
        .START_LAT    (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_ready (start_ready),
        .result_in   (result_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef SYS_ARR_DRAIN_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Array model: column j of row r appears at cycle T+L+r+j, anything else is noise.
    initial forever begin
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            int r;
            r = cyc - cur_t - L - j;
            result_in[j*W +: W] = (cur_valid && r >= 0 && r < N) ? cur_data[r][j] : $urandom;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (rdy_mode == 1) ? ~out_ready : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdy_mode == 3) out_ready = 1'b0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            cur_valid = 0;
            exp_done = -1;
            stall = 0;
        end else begin
            if (start && start_ready) begin
                cur_t = cyc;
                cur_valid = 1;
                exp_done = cyc + L + 2*N - 2;
                for (int r = 0; r < N; r++) begin
                    row_t e;
                    for (int j = 0; j < N; j++) begin
                        cur_data[r][j] = (tile_mode == 0) ? $urandom : 32'(100*r + j);
                        if (tile_mode == 2 && r == 0 && j == 3) cur_data[r][j] = 32'hFFFF_FFF6;
                        e.d[j*W +: W] = relu(cur_data[r][j]);
                    end
                    e.r = r;
                    exp_q.push_back(e);
                end
            end
            if (done || cyc == exp_done) check(done && cyc == exp_done, "done_pulse", 288'(done), 288'(cyc == exp_done));
            if (stall) check(out_valid && out_data == st_data && out_row == st_row, "stall_stable",
                             {out_valid, out_row, out_data}, {1'b1, st_row, st_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check(0, "unexpected_row", {out_row, out_data}, 288'(0));
                else begin
                    row_t e;
                    e = exp_q.pop_front();
                    check(out_data == e.d && out_row == 3'(e.r), "row", {out_row, out_data}, {3'(e.r), e.d});
                end
            end
            stall = out_valid && !out_ready;
            st_data = out_data;
            st_row = out_row;
        end
    end

    task automatic do_start(output int t);
        bit acc;
        acc = 0;
        t = -1;
        @(posedge clk);
        #1 start = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (start_ready) begin
                acc = 1;
                t = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!acc) check(0, "start_timeout", 288'(start_ready), 288'(1));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 600 && !idle; i++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && !out_valid && cyc > exp_done;
        end
        check(idle, "drain_idle", 288'(exp_q.size()), 288'(0));
    endtask

    initial begin
        int t;
        logic [W*N-1:0] row0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check(out_valid == 1'b0, "rst_out_valid", 288'(out_valid), 288'(0));
        check(out_data == '0, "rst_out_data", 288'(out_data), 288'(0));
        check(out_row == '0, "rst_out_row", 288'(out_row), 288'(0));
        check(done == 1'b0, "rst_done", 288'(done), 288'(0));
        check(start_ready == 1'b1, "rst_start_ready", 288'(start_ready), 288'(1));

        tile_mode = 1;
        do_start(t);
        repeat (L + N - 1) @(negedge clk);
        check(out_valid == 1'b0, "valid_before_first", 288'(out_valid), 288'(0));
        @(negedge clk);
        for (int j = 0; j < N; j++) row0[j*W +: W] = 32'(j);
        check(out_valid && out_data == row0 && out_row == 3'd0, "first_row",
              {out_valid, out_row, out_data}, {1'b1, 3'd0, row0});
        wait_idle();

        rdy_mode = 3;
        tile_mode = 0;
        do_start(t);
        repeat (L + 2*N) @(negedge clk);
        check(start_ready == 1'b1, "ready_half_full", 288'(start_ready), 288'(1));
        check(out_valid == 1'b1, "valid_held", 288'(out_valid), 288'(1));
        do_start(t);
        repeat (L + 2*N) @(negedge clk);
        check(start_ready == 1'b0, "ready_full", 288'(start_ready), 288'(0));
        rdy_mode = 0;
        wait_idle();

        rdy_mode = 1;
        repeat (3) do_start(t);
        wait_idle();

        rdy_mode = 0;
        tile_mode = 2;
        do_start(t);
        wait_idle();

        tile_mode = 1;
        do_start(t);
        repeat (L + N + 1) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check(out_valid == 1'b0, "post_rst_valid", 288'(out_valid), 288'(0));
        check(start_ready == 1'b1, "post_rst_ready", 288'(start_ready), 288'(1));
        repeat (30) @(negedge clk);

        rdy_mode = 2;
        tile_mode = 0;
        repeat (400) begin
            @(posedge clk);
            #1 start = ($urandom_range(0, 2) == 0);
        end
        start = 1'b0;
        rdy_mode = 0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
